// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM state and owner encodings, default widths/latency.
package riscv_mem_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ADDR   = 2'd1,
      ARB_ACCESS = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MEM_LAT = 1;

   // Bit 0 = IF, bit 1 = LS; used to ignore the finishing owner's request in DONE.
   function automatic logic [1:0] owner_mask(input owner_t o);
      return (o == OWN_LS) ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester-side and memory-side signals of the IF/LS memory arbiter.
interface riscv_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_done;
   logic [DATA_W-1:0] ls_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_RE;
   logic              mem_WE;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
             mem_addr, mem_wdata, mem_RE, mem_WE, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
             mem_addr, mem_wdata, mem_RE, mem_WE, busy
   );
endinterface

// File: rtl/riscv_mem_arbiter_pick.sv
// Combinational winner select between IF and LS. RISCV_ARB_RR_EN selects round-robin on ties,
// otherwise LS has fixed priority.
module riscv_arb_pick
   import riscv_mem_arbiter_pkg::*;
(
   input  logic       if_req,
   input  logic       ls_req,
`ifdef RISCV_ARB_RR_EN
   input  owner_t     ptr,
`endif
   input  logic [1:0] mask,
   output logic       vld,
   output owner_t     win
);
   logic want_if, want_ls;

   always_comb begin
      want_if = if_req & ~mask[0];
      want_ls = ls_req & ~mask[1];
      vld     = want_if | want_ls;
`ifdef RISCV_ARB_RR_EN
      if (want_if && want_ls) win = ptr;
      else                    win = want_ls ? OWN_LS : OWN_IF;
`else
      win = want_ls ? OWN_LS : OWN_IF;
`endif
   end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter for IF and LS: IDLE -> ADDR -> ACCESS(MEM_LAT) -> DONE.
// Define RISCV_ARB_RR_EN for round-robin; default is fixed LS-over-IF priority.
module riscv_mem_arbiter
   import riscv_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input logic clk,
   input logic rst_n,
   riscv_mem_arbiter_if.slave bus
);
   localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1) begin : g_bad_lat
      $error("riscv_mem_arbiter: MEM_LAT must be >= 1");
   end

   arb_state_t       state;
   owner_t           owner;
   logic             lat_we;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       mask;
   logic             pick_vld;
   owner_t           pick_win;

`ifdef RISCV_ARB_RR_EN
   owner_t ptr;
`endif

   assign mask = (state == ARB_DONE) ? owner_mask(owner) : 2'b00;

   riscv_arb_pick u_pick (
      .if_req (bus.if_req),
      .ls_req (bus.ls_req),
`ifdef RISCV_ARB_RR_EN
      .ptr    (ptr),
`endif
      .mask   (mask),
      .vld    (pick_vld),
      .win    (pick_win)
   );

   // Every output is registered from next-state decisions, so req never reaches gnt combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB_IDLE;
         owner         <= OWN_IF;
         lat_we        <= 1'b0;
         cnt           <= '0;
         bus.if_gnt    <= 1'b0;
         bus.if_done   <= 1'b0;
         bus.if_rdata  <= '0;
         bus.ls_gnt    <= 1'b0;
         bus.ls_done   <= 1'b0;
         bus.ls_rdata  <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_RE    <= 1'b0;
         bus.mem_WE    <= 1'b0;
         bus.busy      <= 1'b0;
`ifdef RISCV_ARB_RR_EN
         ptr           <= OWN_IF;
`endif
      end else begin
         bus.if_gnt  <= 1'b0;
         bus.ls_gnt  <= 1'b0;
         bus.if_done <= 1'b0;
         bus.ls_done <= 1'b0;
         bus.mem_RE  <= 1'b0;
         bus.mem_WE  <= 1'b0;
         case (state)
            ARB_IDLE, ARB_DONE: begin
`ifdef RISCV_ARB_RR_EN
               if (state == ARB_DONE) ptr <= (owner == OWN_IF) ? OWN_LS : OWN_IF;
`endif
               bus.busy <= pick_vld;
               if (pick_vld) begin
                  state <= ARB_ADDR;
                  owner <= pick_win;
                  if (pick_win == OWN_LS) begin
                     bus.mem_addr  <= bus.ls_addr;
                     bus.mem_wdata <= bus.ls_wdata;
                     lat_we        <= bus.ls_we;
                     bus.ls_gnt    <= 1'b1;
                  end else begin
                     bus.mem_addr  <= bus.if_addr;
                     bus.mem_wdata <= '0;
                     lat_we        <= 1'b0;
                     bus.if_gnt    <= 1'b1;
                  end
               end else begin
                  state <= ARB_IDLE;
               end
            end
            ARB_ADDR: begin
               state      <= ARB_ACCESS;
               cnt        <= '0;
               bus.mem_RE <= !lat_we;
               bus.mem_WE <= lat_we;
            end
            ARB_ACCESS: begin
               if (cnt == CNT_LAST) begin
                  state <= ARB_DONE;
                  if (owner == OWN_LS) begin
                     bus.ls_done <= 1'b1;
                     if (!lat_we) bus.ls_rdata <= bus.mem_rdata;
                  end else begin
                     bus.if_done  <= 1'b1;
                     bus.if_rdata <= bus.mem_rdata;
                  end
               end else begin
                  cnt        <= cnt + 1'b1;
                  bus.mem_RE <= !lat_we;
                  bus.mem_WE <= lat_we;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: one MEM_LAT=1 and one MEM_LAT=3 instance on a shared clock/reset.
module tb_riscv_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

   riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h100: return 32'h00500093;
         32'h104: return 32'h00A00113;
         32'h300: return 32'h12345678;
         default: return {16'hBAD0, a[15:0]};
      endcase
   endfunction

   assign bus1.mem_rdata = mem_model(bus1.mem_addr);
   assign bus3.mem_rdata = mem_model(bus3.mem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus1.if_req = 0; bus1.if_addr = '0; bus1.ls_req = 0; bus1.ls_we = 0;
      bus1.ls_addr = '0; bus1.ls_wdata = '0;
      bus3.if_req = 0; bus3.if_addr = '0; bus3.ls_req = 0; bus3.ls_we = 0;
      bus3.ls_addr = '0; bus3.ls_wdata = '0;
   endtask

   task automatic test_reset();
      logic [5:0] ctl;
      #2;
      ctl = {bus1.if_gnt, bus1.ls_gnt, bus1.if_done, bus1.ls_done, bus1.mem_RE, bus1.mem_WE};
      n_chk++; if (ctl !== 6'b0) begin n_fail++; $display("FAIL reset_ctl got %b exp 000000", ctl); end
      n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus1.busy); end
      n_chk++; if (bus1.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus1.mem_addr); end
      n_chk++; if (bus1.if_rdata !== 32'h0 || bus1.ls_rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata got %h/%h exp 0/0", bus1.if_rdata, bus1.ls_rdata); end
      #20;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_if_read();
      bus1.if_req = 1; bus1.if_addr = 32'h100;
      tick(); // c1
      n_chk++; if (bus1.if_gnt !== 1'b1 || bus1.ls_gnt !== 1'b0) begin
         n_fail++; $display("FAIL if_gnt_c1 got if=%b ls=%b exp 1/0", bus1.if_gnt, bus1.ls_gnt); end
      n_chk++; if (bus1.mem_RE !== 1'b0 || bus1.mem_addr !== 32'h100) begin
         n_fail++; $display("FAIL if_addr_c1 got re=%b addr=%h exp 0/100", bus1.mem_RE, bus1.mem_addr); end
      n_chk++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL if_busy_c1 got %b exp 1", bus1.busy); end
      tick(); // c2
      n_chk++; if (bus1.mem_RE !== 1'b1 || bus1.mem_WE !== 1'b0 || bus1.if_gnt !== 1'b0) begin
         n_fail++; $display("FAIL if_re_c2 got re=%b we=%b gnt=%b exp 1/0/0", bus1.mem_RE, bus1.mem_WE, bus1.if_gnt); end
      tick(); // c3
      n_chk++; if (bus1.if_done !== 1'b1 || bus1.mem_RE !== 1'b0) begin
         n_fail++; $display("FAIL if_done_c3 got done=%b re=%b exp 1/0", bus1.if_done, bus1.mem_RE); end
      n_chk++; if (bus1.if_rdata !== 32'h00500093) begin
         n_fail++; $display("FAIL if_rdata got %h exp 00500093", bus1.if_rdata); end
      bus1.if_req = 0;
      tick(); // c4
      n_chk++; if (bus1.if_done !== 1'b0 || bus1.busy !== 1'b0) begin
         n_fail++; $display("FAIL if_end_c4 got done=%b busy=%b exp 0/0", bus1.if_done, bus1.busy); end
   endtask

   task automatic test_both_fixed();
      bus1.if_req = 1; bus1.if_addr = 32'h104;
      bus1.ls_req = 1; bus1.ls_we = 0; bus1.ls_addr = 32'h300;
      tick(); // c1
      n_chk++; if (bus1.ls_gnt !== 1'b1 || bus1.if_gnt !== 1'b0) begin
         n_fail++; $display("FAIL both_first_gnt got ls=%b if=%b exp 1/0", bus1.ls_gnt, bus1.if_gnt); end
      tick(); // c2
      n_chk++; if (bus1.mem_RE !== 1'b1 || bus1.mem_addr !== 32'h300) begin
         n_fail++; $display("FAIL both_ls_re got re=%b addr=%h exp 1/300", bus1.mem_RE, bus1.mem_addr); end
      tick(); // c3
      n_chk++; if (bus1.ls_done !== 1'b1 || bus1.if_done !== 1'b0 || bus1.ls_rdata !== 32'h12345678) begin
         n_fail++; $display("FAIL both_ls_done got done=%b/%b rdata=%h exp 1/0/12345678",
                            bus1.ls_done, bus1.if_done, bus1.ls_rdata); end
      bus1.ls_req = 0;
      tick(); // c4: IF granted straight from DONE
      n_chk++; if (bus1.if_gnt !== 1'b1 || bus1.busy !== 1'b1 || bus1.mem_addr !== 32'h104) begin
         n_fail++; $display("FAIL both_b2b_gnt got gnt=%b busy=%b addr=%h exp 1/1/104",
                            bus1.if_gnt, bus1.busy, bus1.mem_addr); end
      tick(); // c5
      n_chk++; if (bus1.mem_RE !== 1'b1) begin n_fail++; $display("FAIL both_if_re got %b exp 1", bus1.mem_RE); end
      tick(); // c6
      n_chk++; if (bus1.if_done !== 1'b1 || bus1.if_rdata !== 32'h00A00113) begin
         n_fail++; $display("FAIL both_if_done got done=%b rdata=%h exp 1/00a00113", bus1.if_done, bus1.if_rdata); end
      bus1.if_req = 0;
      tick();
   endtask

   task automatic test_ls_store();
      int we_cnt = 0, done_cnt = 0, bad_bus = 0, re_cnt = 0;
      bus1.ls_req = 1; bus1.ls_we = 1; bus1.ls_addr = 32'h200; bus1.ls_wdata = 32'hDEADBEEF;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus1.mem_WE) begin
            we_cnt++;
            if (bus1.mem_addr !== 32'h200 || bus1.mem_wdata !== 32'hDEADBEEF) bad_bus++;
         end
         if (bus1.mem_RE) re_cnt++;
         if (bus1.ls_done) begin done_cnt++; bus1.ls_req = 0; bus1.ls_we = 0; end
      end
      n_chk++; if (we_cnt != 1) begin n_fail++; $display("FAIL st_we_cycles got %0d exp 1", we_cnt); end
      n_chk++; if (bad_bus != 0 || re_cnt != 0) begin
         n_fail++; $display("FAIL st_bus got bad=%0d re=%0d exp 0/0", bad_bus, re_cnt); end
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL st_done_cnt got %0d exp 1", done_cnt); end
      n_chk++; if (bus1.ls_rdata !== 32'h12345678 || bus1.if_rdata !== 32'h00A00113) begin
         n_fail++; $display("FAIL st_rdata_held got %h/%h exp 12345678/00a00113", bus1.ls_rdata, bus1.if_rdata); end
   endtask

   task automatic test_lat3_load();
      int re_cnt = 0, done_at = -1;
      bus3.ls_req = 1; bus3.ls_we = 0; bus3.ls_addr = 32'h300;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (bus3.mem_RE) re_cnt++;
         if (bus3.ls_done) begin
            if (done_at < 0) done_at = c;
            bus3.ls_req = 0;
         end
      end
      n_chk++; if (re_cnt != 3) begin n_fail++; $display("FAIL lat3_re_cycles got %0d exp 3", re_cnt); end
      n_chk++; if (done_at != 5) begin n_fail++; $display("FAIL lat3_done_cycle got %0d exp 5", done_at); end
      n_chk++; if (bus3.ls_rdata !== 32'h12345678) begin
         n_fail++; $display("FAIL lat3_rdata got %h exp 12345678", bus3.ls_rdata); end
   endtask

   task automatic test_mid_reset();
      int done_cnt = 0;
      bus3.if_req = 1; bus3.if_addr = 32'h100;
      tick(); tick(); // c2: in ACCESS
      n_chk++; if (bus3.mem_RE !== 1'b1) begin n_fail++; $display("FAIL mr_pre_re got %b exp 1", bus3.mem_RE); end
      #3 rst_n = 1'b0;
      #1;
      n_chk++; if (bus3.mem_RE !== 1'b0 || bus3.busy !== 1'b0) begin
         n_fail++; $display("FAIL mr_drop got re=%b busy=%b exp 0/0", bus3.mem_RE, bus3.busy); end
      n_chk++; if (bus3.mem_addr !== 32'h0 || bus3.ls_rdata !== 32'h0 || bus1.if_rdata !== 32'h0) begin
         n_fail++; $display("FAIL mr_clear got addr=%h ls=%h if1=%h exp 0/0/0",
                            bus3.mem_addr, bus3.ls_rdata, bus1.if_rdata); end
      bus3.if_req = 0;
      #2 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus3.if_done) done_cnt++;
      end
      n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL mr_lost_done got %0d exp 0", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic [3:0] got = '0;
      logic [3:0] exp_order;
`ifdef RISCV_ARB_RR_EN
      exp_order = 4'b1010; // bit i = owner of grant i (1=LS): IF, LS, IF, LS
`else
      exp_order = 4'b0101; // LS, IF, LS, IF
`endif
      bus1.if_req = 1; bus1.if_addr = 32'h104;
      bus1.ls_req = 1; bus1.ls_we = 0; bus1.ls_addr = 32'h300;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         if (bus1.if_gnt) begin got[n] = 1'b0; n++; end
         else if (bus1.ls_gnt) begin got[n] = 1'b1; n++; end
      end
      bus1.if_req = 0; bus1.ls_req = 0;
      n_chk++; if (n != 4) begin n_fail++; $display("FAIL b2b_grant_count got %0d exp 4", n); end
      n_chk++; if (got !== exp_order) begin n_fail++; $display("FAIL b2b_order got %b exp %b", got, exp_order); end
      for (int c = 0; c < 6; c++) tick();
      n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b exp 0", bus1.busy); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_if_read();
      test_both_fixed();
      test_ls_store();
      test_lat3_load();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
